ece571f23_g5_aes_invmixcolumns_iter: RTL and testbench

ECE571F23_G5_AES_INVMIXCOLUMNS_ITER -- requirements
Module: ece571f23_g5_aes_invmixcolumns_iter

---
 rtl/ece571f23_g5_aes_invmixcolumns_iter.sv | 120 ++++++++++++
 tb/tb_ece571f23_g5_aes_invmixcolumns_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ece571f23_g5_aes_invmixcolumns_iter.sv
// AES InvMixColumns, one shared column datapath stepped over four cycles.
// Define AES_INVMIX_ONECYC_EN to compute all four columns in a single cycle.
module ece571f23_g5_aes_invmixcolumns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] cap;
    logic         accept;
    logic         last_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 9/b/d/e multiples share the x2/x4/x8 chain of each input byte
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {
            me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]
        };
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

`ifdef AES_INVMIX_ONECYC_EN
    assign last_col = 1'b1;
`else
    logic [1:0]  col_cnt;
    logic [31:0] col_in;
    logic [31:0] col_res;

    assign col_in   = cap[{col_cnt, 5'd0} +: 32];
    assign col_res  = inv_col(col_in);
    assign last_col = (col_cnt == 2'd3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (last_col) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AES_INVMIX_ONECYC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap      <= '0;
            out_data <= '0;
        end else if (accept) begin
            cap <= in_data;
        end else if (state == CALC) begin
            out_data <= {inv_col(cap[127:96]), inv_col(cap[95:64]),
                         inv_col(cap[63:32]), inv_col(cap[31:0])};
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap      <= '0;
            out_data <= '0;
            col_cnt  <= 2'd0;
        end else if (accept) begin
            cap     <= in_data;
            col_cnt <= 2'd0;
        end else if (state == CALC) begin
            out_data[{col_cnt, 5'd0} +: 32] <= col_res;
            col_cnt <= col_cnt + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ece571f23_g5_aes_invmixcolumns_iter.sv
// Scoreboard bench for the InvMixColumns block: directed vectors,
// round trip through a forward MixColumns model, backpressure, reset.
module tb_ece571f23_g5_aes_invmixcolumns_iter;

`ifdef AES_INVMIX_ONECYC_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic [127:0] sb[$];
    int           n_chk;
    int           n_err;
    int           n_out;

    ece571f23_g5_aes_invmixcolumns_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // forward MixColumns reference
    function automatic logic [127:0] mix(input logic [127:0] x);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[32*c+24 +: 8];
            a1 = x[32*c+16 +: 8];
            a2 = x[32*c+8  +: 8];
            a3 = x[32*c    +: 8];
            r[32*c+24 +: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
            r[32*c+16 +: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
            r[32*c+8  +: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
            r[32*c    +: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
        return r;
    endfunction

    // consumer side: pop on every cycle the handshake will complete
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $error("FAIL unexpected_out observed=%h expected=none",
                       out_data);
            end else begin
                check("result", out_data, sb.pop_front());
                n_out++;
            end
        end
    end

    task automatic accept_vec(input logic [127:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 128'(n >= 50), 128'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] exp);
        int lat;
        sb.push_back(exp);
        accept_vec(d);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(LAT));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] held;
        int           base;
        int           n;
        n_chk     = 0;
        n_err     = 0;
        n_out     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'h0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
             128'hdb135345_f20a225c_01010101_c6c6c6c6);
        drain();
        send(128'h0, 128'h0);
        drain();
        send({4{32'hffffffff}}, {4{32'hffffffff}});
        drain();

        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(mix(x), x);
            drain();
        end

        // backpressure: hold the result while inputs toggle
        out_ready = 1'b0;
        x = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        send(mix(x), x);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", 128'(in_ready), 128'(1));
        check("bp_release_valid", 128'(out_valid), 128'(0));
        drain();

        // reset after the second CALC edge discards the computation
        out_ready = 1'b0;
        accept_vec({4{32'h5a5a_c3c3}});
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_data", out_data, 128'h0);
        check("mid_rst_ready", 128'(in_ready), 128'(1));
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        x = 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0;
        send(mix(x), x);
        drain();

        // back-to-back with in_valid held high
        x = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        held = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
        sb.push_back(x);
        sb.push_back(held);
        base = n_out;
        accept_vec(mix(x));
        in_data  = mix(held);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_consumed", 128'(n_out - base), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("b2b_both_out", 128'(n_out - base), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
